// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared types and constants for the sysid checker: FSM states, word addresses,
// default expected values and the captured-word payload.
package first_nios2_system_sysid_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned TIMER_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [WORD_W-1:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [WORD_W-1:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1363115347;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } sysid_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] id;
    logic [WORD_W-1:0] ts;
  } sysid_words_t;

  function automatic logic is_busy_state(sysid_state_t s);
    return (s == RD_ID) || (s == RD_TS) || (s == CMP);
  endfunction

  function automatic logic is_read_state(sysid_state_t s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

endpackage

// File: rtl/first_nios2_system_sysid_read_timer.sv
// Shared counter used both for read-latency sampling and for the recheck period.
// Clears on request, counts up while enabled and holds once it reaches the terminal value.
module first_nios2_system_sysid_read_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             hit_c
);

  logic [WIDTH-1:0] count;

  assign hit_c = (count == terminal);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !hit_c) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp and checks them.
// Define FIRST_NIOS2_SYSTEM_SYSID_CHECKER_STICKY_EN to add a sticky_fail output latched on any mismatch.
module first_nios2_system_sysid_checker
  import first_nios2_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned RECHECK_PERIOD     = 0,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        mismatch,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
`ifdef FIRST_NIOS2_SYSTEM_SYSID_CHECKER_STICKY_EN
  output logic        sticky_fail,
`endif
  output logic [7:0]  check_count
);

  localparam logic [TIMER_W-1:0] LATENCY_TERM = TIMER_W'(READ_LATENCY);
  localparam bit                 RECHECK_EN   = (RECHECK_PERIOD > 0);
  localparam logic [TIMER_W-1:0] PERIOD_TERM  =
    RECHECK_EN ? TIMER_W'(RECHECK_PERIOD - 1) : TIMER_W'(0);

  sysid_state_t       state;
  sysid_state_t       state_next;
  sysid_words_t       captured;
  logic               timer_clear_c;
  logic               timer_enable_c;
  logic               timer_hit_c;
  logic [TIMER_W-1:0] timer_terminal_c;
  logic               sample_id_c;
  logic               sample_ts_c;
  logic               compare_c;
  logic               id_match_c;
  logic               ts_match_c;

  assign id_match_c = (captured.id == EXPECTED_ID);
  assign ts_match_c = (captured.ts == EXPECTED_TIMESTAMP);
  assign id_value   = captured.id;
  assign ts_value   = captured.ts;

  // One counter serves both read states (latency) and DONE (recheck period).
  first_nios2_system_sysid_read_timer #(
    .WIDTH (TIMER_W)
  ) u_read_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear_c),
    .enable   (timer_enable_c),
    .terminal (timer_terminal_c),
    .hit_c    (timer_hit_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    timer_terminal_c = LATENCY_TERM;
    timer_enable_c   = 1'b0;
    sample_id_c      = 1'b0;
    sample_ts_c      = 1'b0;
    compare_c        = 1'b0;
    case (state)
      IDLE: begin
        if (start || AUTO_START) begin
          state_next = RD_ID;
        end
      end
      RD_ID: begin
        timer_enable_c = 1'b1;
        if (timer_hit_c) begin
          sample_id_c = 1'b1;
          state_next  = RD_TS;
        end
      end
      RD_TS: begin
        timer_enable_c = 1'b1;
        if (timer_hit_c) begin
          sample_ts_c = 1'b1;
          state_next  = CMP;
        end
      end
      CMP: begin
        compare_c  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        timer_terminal_c = PERIOD_TERM;
        timer_enable_c   = RECHECK_EN;
        // A start landing on the expiry cycle still yields a single transition.
        if (start || (RECHECK_EN && timer_hit_c)) begin
          state_next = RD_ID;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    timer_clear_c = (state_next != state);
  end

  // Bus strobes and status are registered from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sysid_read    <= 1'b0;
      sysid_address <= SYSID_ADDR_ID;
      busy          <= 1'b0;
      done          <= 1'b0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      mismatch      <= 1'b0;
      check_count   <= '0;
      captured      <= '0;
`ifdef FIRST_NIOS2_SYSTEM_SYSID_CHECKER_STICKY_EN
      sticky_fail   <= 1'b0;
`endif
    end else begin
      sysid_read    <= is_read_state(state_next);
      sysid_address <= (state_next == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy          <= is_busy_state(state_next);
      mismatch      <= 1'b0;
      if (sample_id_c) begin
        captured.id <= sysid_readdata;
      end
      if (sample_ts_c) begin
        captured.ts <= sysid_readdata;
      end
      if (compare_c) begin
        id_ok       <= id_match_c;
        ts_ok       <= ts_match_c;
        done        <= 1'b1;
        check_count <= check_count + COUNT_W'(1);
        mismatch    <= !(id_match_c && ts_match_c);
`ifdef FIRST_NIOS2_SYSTEM_SYSID_CHECKER_STICKY_EN
        if (!(id_match_c && ts_match_c)) begin
          sticky_fail <= 1'b1;
        end
`endif
      end
    end
  end

endmodule
